// File: rtl/s_ingress_pkt_buffer.sv
// rtl/s_ingress_pkt_buffer.sv - store-and-forward ingress packet buffer with almost-full backpressure
// Optional drop-on-overflow mode is selected with `define S_INGRESS_BUF_DROP_EN (default: lossless).
module s_ingress_pkt_buffer #(
  parameter int DEPTH     = 512,
  parameter int BP_THRESH = 64
) (
  input  logic        clk_line,
  input  logic        rst,
  input  logic        backpressure_in,
  output logic        backpressure_out,
  input  logic        stream_in_TLAST,
  input  logic        stream_in_TVALID,
  output logic        stream_in_TREADY,
  input  logic [31:0] stream_in_TDATA,
  input  logic [3:0]  stream_in_TKEEP,
  output logic        stream_out_TLAST,
  output logic        stream_out_TVALID,
  input  logic        stream_out_TREADY,
  output logic [31:0] stream_out_TDATA,
  output logic [3:0]  stream_out_TKEEP,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] THRESH_P = PW'(BP_THRESH);
  localparam logic [PW-1:0] ONE_P    = PW'(1);

  logic [36:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_wr_commit;
  logic [PW-1:0] r_rd_ptr;
  logic [36:0]   r_rd_data;
  logic          r_rd_vld;
  logic [36:0]   r_o_data;
  logic          r_o_vld;
  logic [36:0]   r_s_data;
  logic          r_s_vld;
  logic          r_bp_out;
  logic [15:0]   r_pkt_cnt;

  logic [PW-1:0] w_used;
  logic [PW-1:0] w_free;
  logic          w_full;
  logic          w_in_rdy;
  logic          w_wr_en;
  logic          w_readable;
  logic          w_out_fire;
  logic [2:0]    w_occ;
  logic          w_rd_issue;

  assign w_used     = r_wr_ptr - r_rd_ptr;
  assign w_free     = DEPTH_P - w_used;
  assign w_full     = (w_used == DEPTH_P);
  assign w_readable = (r_rd_ptr != r_wr_commit);
  assign w_out_fire = r_o_vld && stream_out_TREADY && !backpressure_in;

  // Beats held or in flight after this edge; keeps the 2-entry output stage from overflowing.
  assign w_occ      = {2'b0, r_o_vld} + {2'b0, r_s_vld} + {2'b0, r_rd_vld} - {2'b0, w_out_fire};
  assign w_rd_issue = !rst && w_readable && (w_occ < 3'd2);

`ifdef S_INGRESS_BUF_DROP_EN
  logic        r_dropping;
  logic [15:0] r_drop_cnt;

  assign w_in_rdy   = 1'b1;
  assign w_wr_en    = !rst && stream_in_TVALID && !r_dropping && !w_full;
  assign drop_count = r_drop_cnt;

  always_ff @(posedge clk_line) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_rd_ptr    <= '0;
      r_dropping  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + ONE_P;
      if (stream_in_TVALID) begin
        if (r_dropping) begin
          if (stream_in_TLAST) r_dropping <= 1'b0;
        end else if (w_full) begin
          // Rewind to the last committed packet and discard the rest of this one.
          r_wr_ptr   <= r_wr_commit;
          r_dropping <= !stream_in_TLAST;
          if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end else begin
          r_wr_ptr <= r_wr_ptr + ONE_P;
          if (stream_in_TLAST) r_wr_commit <= r_wr_ptr + ONE_P;
        end
      end
    end
  end
`else
  logic r_cut;
  logic w_in_fire;

  assign w_in_rdy   = !w_full;
  assign w_in_fire  = stream_in_TVALID && w_in_rdy;
  assign w_wr_en    = !rst && w_in_fire;
  assign drop_count = '0;

  always_ff @(posedge clk_line) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_rd_ptr    <= '0;
      r_cut       <= 1'b0;
    end else begin
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + ONE_P;
      if (w_in_fire) begin
        r_wr_ptr <= r_wr_ptr + ONE_P;
        if (stream_in_TLAST || r_cut) r_wr_commit <= r_wr_ptr + ONE_P;
        if (stream_in_TLAST) r_cut <= 1'b0;
      end else if (w_full && (r_wr_commit == r_rd_ptr)) begin
        // Packet larger than the buffer: release it cut-through until its TLAST.
        r_wr_commit <= r_wr_ptr;
        r_cut       <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk_line) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {stream_in_TLAST, stream_in_TKEEP, stream_in_TDATA};
    if (w_rd_issue) r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
  end

  // Output register plus skid; the skid only fills while the output register is stalled.
  always_ff @(posedge clk_line) begin
    if (rst) begin
      r_rd_vld  <= 1'b0;
      r_o_vld   <= 1'b0;
      r_o_data  <= '0;
      r_s_vld   <= 1'b0;
      r_s_data  <= '0;
      r_bp_out  <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_rd_vld <= w_rd_issue;
      r_bp_out <= (w_free < THRESH_P);
      if (w_out_fire && r_o_data[36] && (r_pkt_cnt != 16'hFFFF)) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_out_fire || !r_o_vld) begin
        if (r_s_vld) begin
          r_o_data <= r_s_data;
          r_o_vld  <= 1'b1;
          r_s_vld  <= r_rd_vld;
          if (r_rd_vld) r_s_data <= r_rd_data;
        end else if (r_rd_vld) begin
          r_o_data <= r_rd_data;
          r_o_vld  <= 1'b1;
        end else begin
          r_o_vld <= 1'b0;
        end
      end else if (r_rd_vld) begin
        r_s_data <= r_rd_data;
        r_s_vld  <= 1'b1;
      end
    end
  end

  assign stream_in_TREADY  = w_in_rdy;
  assign stream_out_TVALID = r_o_vld;
  assign stream_out_TLAST  = r_o_data[36];
  assign stream_out_TKEEP  = r_o_data[35:32];
  assign stream_out_TDATA  = r_o_data[31:0];
  assign backpressure_out  = r_bp_out;
  assign pkt_count         = r_pkt_cnt;

endmodule

// File: doc/s_ingress_pkt_buffer.md
# s_ingress_pkt_buffer

Store-and-forward packet buffer on the ingress path, sitting directly downstream of the ingress protocol adapter and upstream of the MoSAIC tile message queues. It accepts 32-bit AXI-Stream beats and holds each packet until its TLAST beat is written. Only complete packets are then presented downstream, so a tile never sees a partial message. It also generates the line-side backpressure flag from buffer occupancy.

## Interface
- DEPTH, 512, buffer capacity in beats; power of 2, ≥ 16
- BP_THRESH, 64, backpressure_out asserts when free beats < BP_THRESH; 1 ≤ BP_THRESH < DEPTH
- clk_line  in  1  sole clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- backpressure_in  in  1  downstream stall; when high no output beat transfers
- backpressure_out  out  1  registered almost-full flag to upstream
- stream_in_TLAST / TVALID  in  1 / 1  input stream
- stream_in_TREADY  out  1  input ready
- stream_in_TDATA  in  32  input data
- stream_in_TKEEP  in  4  input byte enables, stored unmodified
- stream_out_TLAST / TVALID  out  1 / 1  output stream
- stream_out_TREADY  in  1  output ready
- stream_out_TDATA  out  32  output data
- stream_out_TKEEP  out  4  output byte enables
- pkt_count  out  16  saturating count of packets fully delivered (TLAST beat transferred out)
- drop_count  out  16  saturating count of dropped packets; constant 0 when dropping is compiled out

## Operation
- Storage: DEPTH × 37-bit RAM holding {TLAST, TKEEP, TDATA}, with a synchronous read.
- Pointers: wr_ptr, wr_commit, rd_ptr, each log2(DEPTH)+1 bits, with natural wrap.
  - used = wr_ptr − rd_ptr
  - full = (used == DEPTH)
  - free = DEPTH − used
- Input accept: stream_in_TVALID && stream_in_TREADY.
  - Writes the beat at wr_ptr and increments wr_ptr.
  - On a TLAST beat, wr_commit ← wr_ptr+1 on the same edge.
- Readable region: rd_ptr up to wr_commit. The output stage prefetches from the readable region only.
- Output transfer: stream_out_TVALID && stream_out_TREADY && !backpressure_in.
  - stream_out_TVALID does not depend on backpressure_in or TREADY.
  - Once asserted, TVALID and the payload hold until the beat transfers.
- Output stage: 2-entry register pipeline (RAM read register plus skid register), giving full throughput with no bubbles.
- Force-commit in lossless mode: if full && wr_commit == rd_ptr (packet longer than DEPTH), wr_commit ← wr_ptr. The buffer then degrades to cut-through for that packet. The rest of that packet commits beat by beat until its TLAST.
- backpressure_out ← (free < BP_THRESH), registered, so it is one cycle behind occupancy.

## Timing
- Reset values:
  - stream_out_TVALID, TLAST, TDATA, TKEEP = 0
  - backpressure_out = 0
  - stream_in_TREADY = 1
  - pkt_count = 0, drop_count = 0
  - all pointers 0, drop state cleared
- Reset mid-packet discards all content, including any in-flight partial packet. The next accepted beat starts a new packet.
- Latency: a TLAST beat accepted at edge N, with the output stage empty, gives stream_out_TVALID high after edge N+2 carrying the packet's first beat.
- Throughput: 1 beat/cycle sustained in both directions when TREADY=1 and backpressure_in=0.
- Simultaneous write and read in the same cycle are both allowed; used is unchanged.
- Simultaneous commit and last-beat read are allowed.
- Full and empty are computed from pointers at the clock edge; there is no combinational path from stream_out_TREADY to stream_in_TREADY.
- Lossless mode: stream_in_TREADY = !full.

## Configuration
- S_INGRESS_BUF_DROP_EN defined (drop mode):
  - stream_in_TREADY is constantly 1 outside reset.
  - If a beat arrives while full, wr_ptr ← wr_commit, and the remaining beats are discarded through TLAST inclusive.
  - If the overflowing beat itself carries TLAST, only that packet is discarded.
  - drop_count increments once per dropped packet.
  - Force-commit is disabled, so packets longer than DEPTH are always dropped.
- S_INGRESS_BUF_DROP_EN undefined (lossless mode):
  - TREADY = !full, with force-commit as described in Operation.
  - drop_count is tied to 0.

## Test plan
- Reset, then a single 4-beat packet (data 0x1..0x4, TKEEP 0xF, last TKEEP 0x3) with TREADY=1 → TVALID rises 2 cycles after the TLAST accept; beats come out in order with TKEEP preserved; pkt_count=1.
- Send a 6-beat packet with the TLAST beat withheld for 10 cycles → stream_out_TVALID stays 0 throughout; output starts 2 cycles after TLAST.
- DEPTH=16, BP_THRESH=4, downstream stalled, 13 beats written → backpressure_out=1 one cycle after free drops to 3; clears one cycle after reads restore free=4.
- Lossless mode, DEPTH=16, stalled output, a 20-beat packet → TREADY drops at 16 beats; force-commit fires; on release, all 20 beats arrive intact and TLAST is on beat 20.
- Drop mode, DEPTH=16, a 10-beat packet stored then a 10-beat packet sent with the output stalled → the second packet is dropped; drop_count=1; a following 3-beat packet is stored and delivered; pkt_count=2 after drain.
- rst asserted mid-packet during both input and output activity → all outputs reach their reset values on the next edge; a fresh 2-beat packet then passes correctly.
